// File: rtl/music_pkg.sv
// Shared definitions for the music playback path.
//   - Note code range accepted by the tone oscillator (MIDI 21..108, 0 = rest).
//   - Bit positions of the fields inside a 16-bit score ROM entry.
//   - Sequencer FSM state encoding.
//   - validate_note(): maps any code the oscillator cannot play to a rest.
package music_pkg;

  localparam logic [7:0] NOTE_MIN  = 8'd21;
  localparam logic [7:0] NOTE_MAX  = 8'd108;
  localparam logic [7:0] NOTE_REST = 8'd0;

  localparam int NOTE_LSB = 0;
  localparam int NOTE_MSB = 7;
  localparam int DUR_LSB  = 8;
  localparam int DUR_MSB  = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [7:0] validate_note(input logic [7:0] code);
    if (code == NOTE_REST || (code >= NOTE_MIN && code <= NOTE_MAX)) begin
      return code;
    end
    return NOTE_REST;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, score-ROM and note-output signals of the note sequencer.
//   start/stop (pulses), pause/loop (levels)  : game logic -> sequencer
//   rom_addr -> score ROM, rom_data <- score ROM (one cycle read latency)
//   note, busy, beat, done                    : sequencer -> oscillator / game logic
// Modports: master = surrounding system (game logic + ROM), slave = sequencer.
interface note_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [7:0]        note;
  logic              busy;
  logic              beat;
  logic              done;

  modport master (
    output start, stop, pause, loop, rom_data,
    input  rom_addr, note, busy, beat, done
  );

  modport slave (
    input  start, stop, pause, loop, rom_data,
    output rom_addr, note, busy, beat, done
  );
endinterface

// File: rtl/tick_divider.sv
// Tempo tick divider: counts clock cycles within one tempo tick.
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : count this cycle
//   clr_i    : force the count back to 0 (wins over en_i)
//   cnt_o    : current position inside the tick (0..TICK_CYCLES-1)
//   tick_o   : high in the last counted cycle of a tick
module tick_divider #(
  parameter int TICK_CYCLES = 250000,
  parameter int CW          = $clog2(TICK_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          tick_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(TICK_CYCLES - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks a song score in an external ROM and presents one
// note code at a time to the tone oscillator.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : note_sequencer_if.slave
//     start/stop pulses, pause/loop levels from game logic
//     rom_addr/rom_data to the score ROM (data one cycle after address)
//     note (0 = silent), busy, beat (tick pulse), done (end-of-score pulse)
// Every output is a register; the note register is loaded with the value
// that belongs to the position the FSM/divider is moving into.
module note_sequencer #(
  parameter int TICK_CYCLES = 250000,
  parameter int GAP_CYCLES  = 0,
  parameter int ADDR_W      = 6
) (
  input  logic            clk,
  input  logic            rst,
  note_sequencer_if.slave bus
);
  import music_pkg::*;

  localparam int                CW        = $clog2(TICK_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [7:0]        note_q;
  logic [7:0]        code_q;
  logic [7:0]        tick_rem_q;
  logic              busy_q, beat_q, done_q;

  logic [CW-1:0]     div_cnt, cnt_next;
  logic              tick, div_en, div_clr;
  logic [7:0]        entry_note, entry_dur, rem_next;

  // Articulation gap: the tail of the last tick of a note is silent.
  function automatic logic [7:0] gate_note(input logic [7:0]    code,
                                           input logic [7:0]    rem,
                                           input logic [CW-1:0] cnt);
    if (rem == 8'd1 && int'(cnt) >= (TICK_CYCLES - GAP_CYCLES)) begin
      return NOTE_REST;
    end
    return code;
  endfunction

  assign entry_note = bus.rom_data[NOTE_MSB:NOTE_LSB];
  assign entry_dur  = bus.rom_data[DUR_MSB:DUR_LSB];

  assign div_en  = (state_q == ST_PLAY) && !bus.pause;
  assign div_clr = (state_q != ST_PLAY) || bus.stop || bus.start;

  // Position the divider and tick counter move to at the next edge.
  assign cnt_next = tick ? '0 : div_cnt + CW'(1);
  assign rem_next = tick ? tick_rem_q - 8'd1 : tick_rem_q;

  tick_divider #(
    .TICK_CYCLES(TICK_CYCLES),
    .CW         (CW)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .en_i  (div_en),
    .clr_i (div_clr),
    .cnt_o (div_cnt),
    .tick_o(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      note_q     <= NOTE_REST;
      code_q     <= NOTE_REST;
      tick_rem_q <= '0;
      busy_q     <= 1'b0;
      beat_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      beat_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q    <= ST_IDLE;
        note_q     <= NOTE_REST;
        tick_rem_q <= '0;
        busy_q     <= 1'b0;
      end else if (bus.start) begin
        // Restart from the top; note holds until the first entry is loaded.
        state_q    <= ST_FETCH;
        rom_addr_q <= '0;
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            note_q <= NOTE_REST;
          end
          ST_FETCH: begin
            state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            if (entry_dur == 8'd0) begin
              if (bus.loop) begin
                rom_addr_q <= '0;
                state_q    <= ST_FETCH;
              end else begin
                note_q  <= NOTE_REST;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end else begin
              code_q     <= validate_note(entry_note);
              tick_rem_q <= entry_dur;
              note_q     <= bus.pause ? NOTE_REST
                                      : gate_note(validate_note(entry_note), entry_dur, '0);
              state_q    <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (bus.pause) begin
              note_q <= NOTE_REST;
            end else if (tick && tick_rem_q == 8'd1) begin
              // Note finished; FETCH/LOAD keep showing its final value.
              beat_q     <= 1'b1;
              tick_rem_q <= 8'd0;
              note_q     <= gate_note(code_q, 8'd1, CW'(TICK_CYCLES - 1));
              if (rom_addr_q != ADDR_LAST) begin
                rom_addr_q <= rom_addr_q + ADDR_W'(1);
                state_q    <= ST_FETCH;
              end else if (bus.loop) begin
                // Last ROM slot behaves like an end marker.
                rom_addr_q <= '0;
                state_q    <= ST_FETCH;
              end else begin
                note_q  <= NOTE_REST;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end else begin
              beat_q     <= tick;
              tick_rem_q <= rem_next;
              note_q     <= gate_note(code_q, rem_next, cnt_next);
            end
          end
          ST_DONE: begin
            note_q  <= NOTE_REST;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            note_q  <= NOTE_REST;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.note     = note_q;
  assign bus.busy     = busy_q;
  assign bus.beat     = beat_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  localparam int TICK = 4;
  localparam int GAP  = 1;
  localparam int AW   = 3;

  typedef struct {
    logic [7:0]    note;
    logic          busy;
    logic          beat;
    logic          done;
    logic [AW-1:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rom [8];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  note_sequencer_if #(.ADDR_W(AW)) bus ();

  note_sequencer #(
    .TICK_CYCLES(TICK),
    .GAP_CYCLES (GAP),
    .ADDR_W     (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Synchronous score ROM: data follows the address by one clock.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  function automatic logic [7:0] legal(input logic [7:0] c);
    return (c == 8'd0 || (c >= 8'd21 && c <= 8'd108)) ? c : 8'd0;
  endfunction

  function automatic exp_t mk(input logic [7:0] n, input logic b, input logic bt,
                              input logic d, input int a);
    exp_t e;
    e.note = n; e.busy = b; e.beat = bt; e.done = d; e.addr = AW'(a);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_cyc(input string tag, input int c, input exp_t e);
    string t;
    t = $sformatf("%s[c%0d]", tag, c);
    chk({t, ".note"}, 32'(bus.note), 32'(e.note));
    chk({t, ".busy"}, 32'(bus.busy), 32'(e.busy));
    chk({t, ".beat"}, 32'(bus.beat), 32'(e.beat));
    chk({t, ".done"}, 32'(bus.done), 32'(e.done));
    chk({t, ".addr"}, 32'(bus.rom_addr), 32'(e.addr));
  endtask

  // Cycle-by-cycle expectation from the score: each entry costs two fetch
  // cycles, then D*TICK cycles of its legal code with the last GAP cycles
  // silent; beat appears one cycle after every tick boundary.
  task automatic build_model(input bit lp, input int limit, input logic [7:0] hold0);
    int         a, d;
    bit         pb, fin;
    logic [7:0] hold, v;
    exp_q.delete();
    a = 0; pb = 0; fin = 0; hold = hold0;
    while (!fin && exp_q.size() < limit) begin
      exp_q.push_back(mk(hold, 1, pb, 0, a));
      exp_q.push_back(mk(hold, 1, 0, 0, a));
      d = int'(rom[a][15:8]);
      v = legal(rom[a][7:0]);
      pb = 0;
      if (d == 0) begin
        if (lp) a = 0;
        else begin
          exp_q.push_back(mk(8'd0, 1, 0, 1, a));
          exp_q.push_back(mk(8'd0, 0, 0, 0, a));
          fin = 1;
        end
      end else begin
        for (int j = 0; j < d * TICK; j++)
          exp_q.push_back(mk((j >= d * TICK - GAP) ? 8'd0 : v, 1,
                             (j > 0 && j % TICK == 0), 0, a));
        hold = (GAP > 0) ? 8'd0 : v;
        pb = 1;
        if (a == 7) begin
          if (lp) a = 0;
          else begin
            exp_q.push_back(mk(8'd0, 1, 1, 1, 7));
            exp_q.push_back(mk(8'd0, 0, 0, 0, 7));
            fin = 1;
          end
        end else a++;
      end
    end
  endtask

  // Pause for cycles ps..ps+pl-1 stretches time: the entry shown at cycle ps
  // repeats pl more times, silent and without beat.
  task automatic stretch_for_pause(input int ps, input int pl);
    exp_t e;
    e = exp_q[ps - 1];
    e.note = 8'd0;
    e.beat = 1'b0;
    for (int k = 0; k < pl; k++) exp_q.insert(ps, e);
  endtask

  // Called at a falling edge; start is seen at the next rising edge, so
  // cycle 1 is the fetch cycle. Leaves off at the falling edge of cycle n.
  task automatic kick(input string tag, input int n, input int ps, input int pl);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_cyc(tag, i + 1, exp_q[i]);
      bus.pause = ((i + 1) >= ps && (i + 1) < ps + pl);
      if (i < n - 1) @(negedge clk);
    end
    bus.pause = 1'b0;
  endtask

  task automatic stop_and_check(input string tag);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk({tag, ".note"}, 32'(bus.note), 32'd0);
      chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".done"}, 32'(bus.done), 32'd0);
      chk({tag, ".beat"}, 32'(bus.beat), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    rom[0] = {8'd2, 8'd60};
    rom[1] = {8'd1, 8'd64};
    rom[2] = {8'd0, 8'd0};
  endtask

  initial begin
    int          n, ps, pl;
    bit          lp;
    logic [7:0]  hold;
    int          r;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.loop = 0;
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;

    // Reset state
    @(negedge clk);
    chk("rst.note", 32'(bus.note), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.beat", 32'(bus.beat), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.addr", 32'(bus.rom_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic score, no loop: plays through and pulses done once
    load_basic();
    bus.loop = 0;
    build_model(0, 400, 8'd0);
    kick("basic", exp_q.size(), 0, 0);
    @(negedge clk);

    // Same score looping
    bus.loop = 1;
    build_model(1, 60, 8'd0);
    kick("loop", 60, 0, 0);
    stop_and_check("loop_stop");

    // Out-of-range codes are silenced but beats continue
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    rom[0] = {8'd1, 8'd5};
    rom[1] = {8'd1, 8'd120};
    bus.loop = 0;
    build_model(0, 400, 8'd0);
    kick("badcode", exp_q.size(), 0, 0);
    @(negedge clk);

    // Pause in the middle of the first note (10 cycles, then random length)
    load_basic();
    for (int t = 0; t < 2; t++) begin
      ps = 5;
      pl = (t == 0) ? 10 : int'($urandom_range(1, 12));
      build_model(0, 400, 8'd0);
      stretch_for_pause(ps, pl);
      kick($sformatf("pause%0d", t), exp_q.size(), ps, pl);
      @(negedge clk);
    end

    // Stop during the second note; then start+stop together
    bus.loop = 1;
    build_model(1, 60, 8'd0);
    kick("stopmid", 14, 0, 0);
    stop_and_check("stopmid_after");
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("startstop.busy", 32'(bus.busy), 32'd0);
      chk("startstop.note", 32'(bus.note), 32'd0);
      @(negedge clk);
    end

    // Full ROM without end marker: last slot ends the score, no wrap
    for (int i = 0; i < 8; i++) rom[i] = {8'd1, 8'(60 + i)};
    bus.loop = 0;
    build_model(0, 400, 8'd0);
    kick("full", exp_q.size(), 0, 0);
    @(negedge clk);
    bus.loop = 1;
    build_model(1, 90, 8'd0);
    kick("fullloop", 90, 0, 0);
    stop_and_check("fullloop_stop");

    // Random scores, loop random; looping runs end by stop or restart
    for (r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        int sel;
        sel = int'($urandom_range(0, 9));
        rom[i][7:0]  = (sel < 2) ? 8'd0 :
                       (sel < 4) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(21, 108));
        rom[i][15:8] = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
      end
      lp = bit'($urandom_range(0, 1));
      bus.loop = lp;
      build_model(lp, 150, 8'd0);
      n = lp ? 100 : exp_q.size();
      kick($sformatf("rnd%0d", r), n, 0, 0);
      if (lp && (r % 2 == 1)) begin
        hold = exp_q[n - 1].note;
        build_model(lp, 80, hold);
        kick($sformatf("rnd%0d_restart", r), 60, 0, 0);
      end
      if (lp) stop_and_check($sformatf("rnd%0d_stop", r));
      else @(negedge clk);
    end

    // Asynchronous reset in the middle of a note
    load_basic();
    bus.loop = 0;
    build_model(0, 400, 8'd0);
    kick("prerst", 6, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst.note", 32'(bus.note), 32'd0);
    chk("arst.busy", 32'(bus.busy), 32'd0);
    chk("arst.beat", 32'(bus.beat), 32'd0);
    chk("arst.done", 32'(bus.done), 32'd0);
    chk("arst.addr", 32'(bus.rom_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("postrst.busy", 32'(bus.busy), 32'd0);
    chk("postrst.note", 32'(bus.note), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
